// File: rtl/l2_mem_responder_if.sv
// Line-granular request/response bundle between the L2 write-back/refill logic
// and main memory. The L2 side is the master; the memory responder is the slave.
interface l2_mem_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/l2_mem_responder.sv
// Main-memory model for the L2 line interface: DEPTH x 128-bit storage with a
// fixed request-to-ready latency and a single-cycle registered completion pulse.
module l2_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 10,
    parameter int DEPTH     = 1024
) (
    input logic               clk,
    input logic               proc_reset,
    l2_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    logic [127:0]          mem_array [DEPTH];
    state_t                state;
    state_t                state_nxt;
    logic [7:0]            cnt;
    logic                  op_write;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [127:0]          wdata_q;
    logic                  ready_q;
    logic [127:0]          rdata_q;
    logic                  req;
    logic                  accept;
    logic                  fire;

    assign req = bus.mem_read | bus.mem_write;

    // Dropping the request while waiting is an abort and wins over completion.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt == 8'd0) begin
                    fire      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= fire;
            rdata_q <= '0;
            if (accept) begin
                op_write <= bus.mem_write;
                addr_q   <= bus.mem_addr[ADDR_BITS-1:0];
                wdata_q  <= bus.mem_wdata;
                cnt      <= LAT_M1;
            end else if (state == WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (fire && !op_write) begin
                rdata_q <= mem_array[addr_q];
            end
        end
    end

    // Storage survives reset; a write commits on the same edge that raises ready.
    always_ff @(posedge clk) begin
        if (fire && op_write) begin
            mem_array[addr_q] <= wdata_q;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: two instances (LATENCY=4 and LATENCY=1)
// with a reference line model and per-port queues of expected completions.
module tb_l2_mem_responder;
    localparam int          LAT_A = 4;
    localparam int          LAT_B = 1;
    localparam logic [27:0] MASK  = 28'h3FF;

    typedef struct {
        int unsigned  cyc;
        bit           rd;
        logic [127:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        proc_reset = 1'b1;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    logic [127:0] mdl_a [int];
    logic [127:0] mdl_b [int];

    l2_mem_responder_if bus_a ();
    l2_mem_responder_if bus_b ();

    l2_mem_responder #(.LATENCY(LAT_A), .ADDR_BITS(10), .DEPTH(1024)) dut_a (
        .clk(clk), .proc_reset(proc_reset), .bus(bus_a)
    );
    l2_mem_responder #(.LATENCY(LAT_B), .ADDR_BITS(10), .DEPTH(1024)) dut_b (
        .clk(clk), .proc_reset(proc_reset), .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mdl_get(input int id, input logic [27:0] a);
        int k = int'(a & MASK);
        if (id == 0) return mdl_a.exists(k) ? mdl_a[k] : '0;
        return mdl_b.exists(k) ? mdl_b[k] : '0;
    endfunction

    task automatic mdl_set(input int id, input logic [27:0] a, input logic [127:0] d);
        int k = int'(a & MASK);
        if (id == 0) mdl_a[k] = d;
        else         mdl_b[k] = d;
    endtask

    task automatic push(input int id, input int unsigned c, input bit rd, input logic [127:0] d);
        exp_t e;
        e.cyc  = c;
        e.rd   = rd;
        e.data = d;
        if (id == 0) qa.push_back(e);
        else         qb.push_back(e);
    endtask

    task automatic drive(input int id, input logic rd, input logic wr,
                         input logic [27:0] a, input logic [127:0] d);
        if (id == 0) begin
            bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.mem_addr = a; bus_a.mem_wdata = d;
        end else begin
            bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.mem_addr = a; bus_b.mem_wdata = d;
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? bus_a.mem_ready : bus_b.mem_ready;
    endfunction

    // Completion monitor: every pulse must match the head of that port's queue.
    task automatic mon(input int id, input logic r, input logic [127:0] d);
        exp_t  e;
        string p = (id == 0) ? "a" : "b";
        int    sz = (id == 0) ? qa.size() : qb.size();
        if (r !== 1'b1) begin
            chk({p, "_rdata_outside_pulse"}, d, '0);
        end else if (sz == 0) begin
            chk({p, "_spurious_ready"}, 128'(r), '0);
        end else begin
            e = (id == 0) ? qa.pop_front() : qb.pop_front();
            chk({p, "_ready_cycle"}, 128'(cyc), 128'(e.cyc));
            if (e.rd) chk({p, "_rdata"}, d, e.data);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.mem_ready, bus_a.mem_rdata);
        mon(1, bus_b.mem_ready, bus_b.mem_rdata);
        assert (!(bus_a.mem_read && bus_a.mem_write)) else $error("protocol error: read and write both raised on port a");
        assert (!(bus_b.mem_read && bus_b.mem_write)) else $error("protocol error: read and write both raised on port b");
    end

    // One request held until ready; optionally address/data change after acceptance.
    task automatic req(input int id, input bit wr, input logic [27:0] a, input logic [127:0] d,
                       input bit tog, input logic [27:0] a2, input logic [127:0] d2);
        int  lat = (id == 0) ? LAT_A : LAT_B;
        bit  seen = 0;
        @(negedge clk);
        push(id, cyc + 1 + lat, !wr, wr ? d : mdl_get(id, a));
        if (wr) mdl_set(id, a, d);
        drive(id, !wr, wr, a, d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tog && i == 0) drive(id, !wr, wr, a2, d2);
            if (rdy(id) === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("ready_seen", 128'(seen), 128'(1));
        drive(id, 1'b0, 1'b0, a, '0);
    endtask

    task automatic abort_req(input bit wr, input logic [27:0] a, input logic [127:0] d);
        @(negedge clk);
        drive(0, !wr, wr, a, d);
        repeat (2) @(negedge clk);
        drive(0, 1'b0, 1'b0, a, '0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("reset_ready_a", 128'(bus_a.mem_ready), '0);
        chk("reset_rdata_a", bus_a.mem_rdata, '0);
        chk("reset_ready_b", 128'(bus_b.mem_ready), '0);
        proc_reset = 1'b0;

        // Basic write then read of line 5.
        req(0, 1, 28'h0000005, 128'hDEADBEEF_00000001_00000002_00000003, 0, '0, '0);
        req(0, 0, 28'h0000005, '0, 0, '0, '0);

        // Write-back of 0x045 immediately followed by refill of 0x085.
        req(0, 1, 28'h0000085, 128'h85858585_11112222_33334444_55556666, 0, '0, '0);
        req(0, 1, 28'h0000045, 128'hAAAAAAAA_00000045_0000A000_FFFF0001, 0, '0, '0);
        req(0, 0, 28'h0000085, '0, 0, '0, '0);
        req(0, 0, 28'h0000045, '0, 0, '0, '0);

        // Aborted read and aborted write leave no pulse and no update.
        abort_req(1'b0, 28'h0000005, '0);
        abort_req(1'b1, 28'h0000005, 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA);
        req(0, 0, 28'h0000005, '0, 0, '0, '0);

        // Reset in the middle of a write to 0x045.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 28'h0000045, 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D);
        repeat (2) @(negedge clk);
        proc_reset = 1'b1;
        #1;
        chk("mid_reset_ready", 128'(bus_a.mem_ready), '0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        proc_reset = 1'b0;
        repeat (2) @(negedge clk);
        req(0, 0, 28'h0000045, '0, 0, '0, '0);
        req(0, 0, 28'h0000005, '0, 0, '0, '0);

        // Aliasing modulo 1024 lines.
        req(0, 1, 28'h0000405, 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3, 0, '0, '0);
        req(0, 0, 28'h0000005, '0, 0, '0, '0);
        req(0, 0, 28'hFFFF805, '0, 0, '0, '0);

        // Address/data changes after acceptance are ignored.
        req(0, 1, 28'h0000010, 128'hC0C0C0C0_00000000_00000000_00000010, 0, '0, '0);
        req(0, 1, 28'h0000011, 128'hD0D0D0D0_00000000_00000000_00000011, 0, '0, '0);
        req(0, 1, 28'h0000013, 128'hF0F0F0F0_00000000_00000000_00000013, 0, '0, '0);
        req(0, 0, 28'h0000010, '0, 1, 28'h0000011, '0);
        req(0, 1, 28'h0000012, 128'hE0E0E0E0_00000000_00000000_00000012, 1,
            28'h0000013, 128'h99999999_99999999_99999999_99999999);
        req(0, 0, 28'h0000012, '0, 0, '0, '0);
        req(0, 0, 28'h0000013, '0, 0, '0, '0);

        // LATENCY=1 instance: single-cycle latency, then a request held across pulses.
        req(1, 1, 28'h0000003, 128'h33333333_44444444_55555555_66666666, 0, '0, '0);
        req(1, 0, 28'h0000003, '0, 0, '0, '0);
        req(1, 0, 28'h0000003, '0, 0, '0, '0);
        @(negedge clk);
        c = cyc;
        drive(1, 1'b1, 1'b0, 28'h0000003, '0);
        push(1, c + 2, 1'b1, mdl_get(1, 28'h3));
        push(1, c + 5, 1'b1, mdl_get(1, 28'h3));
        push(1, c + 8, 1'b1, mdl_get(1, 28'h3));
        repeat (8) @(negedge clk);
        drive(1, 1'b0, 1'b0, '0, '0);

        repeat (6) @(negedge clk);
        chk("a_queue_drained", 128'(qa.size()), '0);
        chk("b_queue_drained", 128'(qb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
